// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default sizes, accumulator sizing, column FSM
// states and message saturation bounds.
package ldpc_pkg;

   localparam int unsigned WIDTH_DEF      = 8;
   localparam int unsigned COL_WEIGHT_DEF = 3;

   // Accumulator width that holds llr + COL_WEIGHT messages without overflow.
   function automatic int unsigned sum_width(input int unsigned w, input int unsigned cw);
      return w + $clog2(cw + 1);
   endfunction

   // Largest symmetric magnitude representable in a w-bit message.
   function automatic int msg_max(input int unsigned w);
      return (2 ** (w - 1)) - 1;
   endfunction

   localparam int MSG_MAX = msg_max(WIDTH_DEF);
   localparam int MSG_MIN = -MSG_MAX;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } col_state_t;

endpackage

// File: rtl/col_sat.sv
// Narrows a SUM_WIDTH extrinsic value to a WIDTH-bit message.
// COL_SAT_EN defined: symmetric saturation to +/-(2^(WIDTH-1)-1).
// COL_SAT_EN undefined: keep the low WIDTH bits (wrap).
module col_sat
   import ldpc_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned SUM_WIDTH = sum_width(WIDTH_DEF, COL_WEIGHT_DEF)
) (
   input  logic signed [SUM_WIDTH-1:0] sum_i,
   output logic        [WIDTH-1:0]     msg_o
);

`ifdef COL_SAT_EN
   localparam logic signed [SUM_WIDTH-1:0] SAT_HI = SUM_WIDTH'(msg_max(WIDTH));
   localparam logic signed [SUM_WIDTH-1:0] SAT_LO = -SAT_HI;

   // Clamp out-of-range sums; in-range values fit in WIDTH bits unchanged.
   always_comb begin
      msg_o = sum_i[WIDTH-1:0];
      if (sum_i > SAT_HI) begin
         msg_o = SAT_HI[WIDTH-1:0];
      end else if (sum_i < SAT_LO) begin
         msg_o = SAT_LO[WIDTH-1:0];
      end
   end
`else
   // Upper sum bits are intentionally dropped in wrap mode.
   logic unused_sum_hi;
   assign unused_sum_hi = ^sum_i[SUM_WIDTH-1:WIDTH];

   // Plain truncation.
   always_comb begin
      msg_o = sum_i[WIDTH-1:0];
   end
`endif

endmodule

// File: rtl/col_node.sv
// LDPC min-sum variable-node (column) processor.
// Accumulates one channel LLR plus COL_WEIGHT check messages, then emits the
// COL_WEIGHT extrinsic messages (total - msg[k], arrival order) and a hard decision.
// Optional feature macro: COL_SAT_EN (symmetric saturation of inputs and outputs).
module col_node
   import ldpc_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned COL_WEIGHT = COL_WEIGHT_DEF,
   parameter int unsigned SUM_WIDTH  = sum_width(WIDTH, COL_WEIGHT)
) (
   input  logic             clk,
   input  logic             xrst,
   input  logic [WIDTH-1:0] i_llr,
   input  logic             i_llr_val,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_val,
   output logic             o_rdy,
   output logic [WIDTH-1:0] o_data,
   output logic             o_val,
   input  logic             i_rdy,
   output logic             o_hard,
   output logic             o_hard_val
);

   localparam int unsigned CNT_W = (COL_WEIGHT > 1) ? $clog2(COL_WEIGHT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(COL_WEIGHT - 1);

   // Sign-extend a message to accumulator width.
   function automatic logic signed [SUM_WIDTH-1:0] sext(input logic [WIDTH-1:0] x);
      return {{(SUM_WIDTH - WIDTH){x[WIDTH-1]}}, x};
   endfunction

   // Input conditioning: with saturation on, the asymmetric most-negative code is
   // folded onto -(2^(WIDTH-1)-1) so every message has a negatable magnitude.
   function automatic logic [WIDTH-1:0] cond_in(input logic [WIDTH-1:0] x);
`ifdef COL_SAT_EN
      if (x == {1'b1, {(WIDTH - 1){1'b0}}}) begin
         return x + WIDTH'(1);
      end
`endif
      return x;
   endfunction

   col_state_t                  state_q, state_d;
   logic        [CNT_W-1:0]     cnt_q, cnt_d;
   logic        [CNT_W-1:0]     idx_q, idx_d;
   logic signed [SUM_WIDTH-1:0] acc_q, acc_d;
   logic        [WIDTH-1:0]     buf_q [COL_WEIGHT];
   logic                        hard_q, hard_d;
   logic                        hard_val_q, hard_val_d;
   logic                        buf_we;

   logic        [WIDTH-1:0]     llr_c;
   logic        [WIDTH-1:0]     data_c;
   logic signed [SUM_WIDTH-1:0] acc_add;
   logic signed [SUM_WIDTH-1:0] ext_sum;
   logic        [WIDTH-1:0]     ext_msg;

   assign llr_c   = cond_in(i_llr);
   assign data_c  = cond_in(i_data);
   assign acc_add = acc_q + sext(data_c);
   assign ext_sum = acc_q - sext(buf_q[idx_q]);

   col_sat #(
      .WIDTH     (WIDTH),
      .SUM_WIDTH (SUM_WIDTH)
   ) u_sat (
      .sum_i (ext_sum),
      .msg_o (ext_msg)
   );

   // Next-state logic: IDLE -> ACC -> OUT -> IDLE.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      hard_d     = hard_q;
      hard_val_d = 1'b0;
      buf_we     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_llr_val) begin
               acc_d   = sext(llr_c);
               cnt_d   = '0;
               state_d = ACC;
            end
         end
         ACC: begin
            if (i_val) begin
               buf_we = 1'b1;
               acc_d  = acc_add;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  // Hard decision taken from the full-width total, never the narrowed one.
                  cnt_d      = '0;
                  idx_d      = '0;
                  hard_d     = acc_add[SUM_WIDTH-1];
                  hard_val_d = 1'b1;
                  state_d    = OUT;
               end
            end
         end
         OUT: begin
            if (i_rdy) begin
               if (idx_q == LAST) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters, accumulator and hard-decision registers.
   always_ff @(posedge clk) begin
      if (xrst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         acc_q      <= '0;
         hard_q     <= 1'b0;
         hard_val_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         hard_q     <= hard_d;
         hard_val_q <= hard_val_d;
      end
   end

   // Message buffer: holds the conditioned messages for extrinsic subtraction.
   always_ff @(posedge clk) begin
      if (xrst) begin
         for (int i = 0; i < COL_WEIGHT; i++) begin
            buf_q[i] <= '0;
         end
      end else if (buf_we) begin
         buf_q[cnt_q] <= data_c;
      end
   end

   // Outputs; o_data is forced to zero outside OUT so idle cycles show no stale data.
   always_comb begin
      o_rdy      = (state_q != OUT);
      o_val      = (state_q == OUT);
      o_data     = (state_q == OUT) ? ext_msg : '0;
      o_hard     = hard_q;
      o_hard_val = hard_val_q;
   end

endmodule
